mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl.sv | 143 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with bounded memory handshakes and an absorbing HALT for illegal ops or timeouts.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PcWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       branch,
  output logic [1:0] ALUOperation,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2,
    MEMACC = 3'd3, WRITEBACK = 3'd4, HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_ADDI = 6'h08;

  state_t     cur;
  logic [5:0] op_q, fn_q;
  logic [7:0] wait_cnt;
  logic       legal, wait_hit;

  // Legality is judged on the live inputs in DECODE, before they are latched.
  always_comb begin
    if (opcode == OP_R)
      legal = func inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    else
      legal = opcode inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI};
  end

  // Timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle; ready wins a tie.
  assign wait_hit = !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= FETCH;
      op_q     <= '0;
      fn_q     <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        FETCH: begin
          if (mem_ready)     cur <= DECODE;
          else if (wait_hit) cur <= HALT;
          else               wait_cnt <= wait_cnt + 8'd1;
        end
        DECODE: begin
          op_q <= opcode;
          fn_q <= func;
          cur  <= legal ? EXECUTE : HALT;
        end
        EXECUTE: begin
          case (op_q)
            OP_LW, OP_SW: cur <= MEMACC;
            OP_BEQ:       cur <= FETCH;
            default:      cur <= WRITEBACK;
          endcase
        end
        MEMACC: begin
          if (mem_ready)     cur <= (op_q == OP_LW) ? WRITEBACK : FETCH;
          else if (wait_hit) cur <= HALT;
          else               wait_cnt <= wait_cnt + 8'd1;
        end
        WRITEBACK: cur <= FETCH;
        HALT:      cur <= HALT;
        default:   cur <= FETCH;
      endcase
    end
  end

  always_comb begin
    PcWrite      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegDst       = 1'b0;
    ALUSrc       = 1'b0;
    MemToReg     = 1'b0;
    branch       = 1'b0;
    ALUOperation = 2'b00;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    mem_timeout  = 1'b0;
    state        = rst ? 3'd0 : cur;
    if (!rst) begin
      case (cur)
        FETCH: begin
          MemRead     = !wait_hit;
          IRWrite     = mem_ready;
          PcWrite     = mem_ready;
          mem_timeout = wait_hit;
        end
        DECODE: illegal = !legal;
        EXECUTE: begin
          if (op_q == OP_R) ALUOperation = 2'b10;
          else if (op_q == OP_BEQ) begin
            ALUOperation = 2'b01;
            branch       = 1'b1;
            PcWrite      = Zero;
            instr_done   = 1'b1;
          end else ALUSrc = 1'b1;
        end
        MEMACC: begin
          if (op_q == OP_LW) MemRead = !wait_hit;
          else               MemWrite = !wait_hit;
          mem_timeout = wait_hit;
          instr_done  = mem_ready && (op_q != OP_LW);
        end
        WRITEBACK: begin
          RegWrite   = 1'b1;
          RegDst     = (op_q == OP_R);
          MemToReg   = (op_q == OP_LW);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic unused_fn;
  assign unused_fn = ^fn_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed cycle-by-cycle checks of the multicycle control FSM against hand-built tables.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, func = '0;
  logic Zero = 1'b0, mem_ready = 1'b0;
  logic PcWrite, IRWrite, RegWrite, MemRead, MemWrite, RegDst, ALUSrc, MemToReg, branch;
  logic [1:0] ALUOperation;
  logic [2:0] state;
  logic instr_done, illegal, mem_timeout;
  int total = 0, bad = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .Zero(Zero), .mem_ready(mem_ready),
    .PcWrite(PcWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
    .branch(branch), .ALUOperation(ALUOperation), .state(state), .instr_done(instr_done),
    .illegal(illegal), .mem_timeout(mem_timeout));

  always #5 clk = ~clk;

  logic [13:0] outs;
  assign outs = {PcWrite, IRWrite, RegWrite, MemRead, MemWrite, RegDst, ALUSrc, MemToReg,
                 branch, ALUOperation, instr_done, illegal, mem_timeout};

  localparam logic [13:0] PCW = 14'h2000, IRW = 14'h1000, RGW = 14'h0800, MRD = 14'h0400,
                          MWR = 14'h0200, RDS = 14'h0100, ASR = 14'h0080, M2R = 14'h0040,
                          BR = 14'h0020, AFN = 14'h0010, ASUB = 14'h0008, DONE = 14'h0004,
                          ILL = 14'h0002, TMO = 14'h0001;

  typedef struct { logic mr; logic z; logic [2:0] st; logic [13:0] o; } vec_t;

  task automatic start(input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0; opcode = op; func = fn;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({state, outs} !== {3'd0, 14'h0}) begin
      bad++; $display("FAIL reset_hold state=%0d outs=%h expected state=0 outs=0000", state, outs);
    end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    total++;
    if ({state, outs} !== {3'd0, MRD}) begin
      bad++; $display("FAIL reset_release state=%0d outs=%h expected state=0 outs=%h", state, outs, MRD);
    end
  endtask

  task automatic test_rtype();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 3'd0, PCW | IRW | MRD});
    v.push_back('{1'b1, 1'b0, 3'd1, 14'h0});
    v.push_back('{1'b1, 1'b0, 3'd2, AFN});
    v.push_back('{1'b1, 1'b0, 3'd4, RGW | RDS | DONE});
    v.push_back('{1'b0, 1'b0, 3'd0, MRD});
    start(6'h00, 6'h20);
    for (int i = 0; i < v.size(); i++) begin
      if (i >= 2) begin opcode = 6'h23; func = 6'h00; end
      mem_ready = v[i].mr; Zero = v[i].z; #1;
      total++;
      if ({state, outs} !== {v[i].st, v[i].o}) begin
        bad++; $display("FAIL rtype cyc=%0d state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, v[i].st, v[i].o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 3'd0, PCW | IRW | MRD});
    v.push_back('{1'b0, 1'b0, 3'd1, 14'h0});
    v.push_back('{1'b0, 1'b0, 3'd2, ASR});
    v.push_back('{1'b0, 1'b0, 3'd3, MRD});
    v.push_back('{1'b0, 1'b0, 3'd3, MRD});
    v.push_back('{1'b0, 1'b0, 3'd3, MRD});
    v.push_back('{1'b1, 1'b0, 3'd3, MRD});
    v.push_back('{1'b0, 1'b0, 3'd4, RGW | M2R | DONE});
    v.push_back('{1'b0, 1'b0, 3'd0, MRD});
    start(6'h23, 6'h00);
    for (int i = 0; i < v.size(); i++) begin
      if (i >= 2) begin opcode = 6'h00; func = 6'h20; end
      mem_ready = v[i].mr; Zero = v[i].z; #1;
      total++;
      if ({state, outs} !== {v[i].st, v[i].o}) begin
        bad++; $display("FAIL lw cyc=%0d state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, v[i].st, v[i].o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    vec_t v[$];
    for (int z = 1; z >= 0; z--) begin
      v.delete();
      v.push_back('{1'b1, 1'(z), 3'd0, PCW | IRW | MRD});
      v.push_back('{1'b0, 1'(z), 3'd1, 14'h0});
      v.push_back('{1'b0, 1'(z), 3'd2, (z != 0 ? PCW : 14'h0) | BR | ASUB | DONE});
      v.push_back('{1'b0, 1'(z), 3'd0, MRD});
      start(6'h04, 6'h00);
      for (int i = 0; i < v.size(); i++) begin
        if (i >= 2) opcode = 6'h3F;
        mem_ready = v[i].mr; Zero = v[i].z; #1;
        total++;
        if ({state, outs} !== {v[i].st, v[i].o}) begin
          bad++; $display("FAIL beq z=%0d cyc=%0d state=%0d outs=%h expected state=%0d outs=%h", z, i, state, outs, v[i].st, v[i].o);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_addi_sw();
    vec_t v[$];
    v.push_back('{1'b1, 1'b0, 3'd0, PCW | IRW | MRD});
    v.push_back('{1'b0, 1'b0, 3'd1, 14'h0});
    v.push_back('{1'b0, 1'b0, 3'd2, ASR});
    v.push_back('{1'b0, 1'b0, 3'd4, RGW | DONE});
    v.push_back('{1'b0, 1'b0, 3'd0, MRD});
    start(6'h08, 6'h00);
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i].mr; #1;
      total++;
      if ({state, outs} !== {v[i].st, v[i].o}) begin
        bad++; $display("FAIL addi cyc=%0d state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, v[i].st, v[i].o);
      end
      @(negedge clk);
    end
    v.delete();
    v.push_back('{1'b1, 1'b0, 3'd0, PCW | IRW | MRD});
    v.push_back('{1'b0, 1'b0, 3'd1, 14'h0});
    v.push_back('{1'b0, 1'b0, 3'd2, ASR});
    v.push_back('{1'b0, 1'b0, 3'd3, MWR});
    v.push_back('{1'b1, 1'b0, 3'd3, MWR | DONE});
    v.push_back('{1'b0, 1'b0, 3'd0, MRD});
    start(6'h2B, 6'h00);
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i].mr; #1;
      total++;
      if ({state, outs} !== {v[i].st, v[i].o}) begin
        bad++; $display("FAIL sw cyc=%0d state=%0d outs=%h expected state=%0d outs=%h", i, state, outs, v[i].st, v[i].o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_reset();
    start(6'h2B, 6'h00);
    mem_ready = 1'b1; @(negedge clk);
    mem_ready = 1'b0; @(negedge clk);
    @(negedge clk); #1;
    total++;
    if ({state, outs} !== {3'd3, MWR}) begin
      bad++; $display("FAIL sw_rst_pre state=%0d outs=%h expected state=3 outs=%h", state, outs, MWR);
    end
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if ({state, outs} !== {3'd0, 14'h0}) begin
      bad++; $display("FAIL sw_rst_hold state=%0d outs=%h expected state=0 outs=0000", state, outs);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if ({state, outs} !== {3'd0, MRD}) begin
      bad++; $display("FAIL sw_rst_after state=%0d outs=%h expected state=0 outs=%h", state, outs, MRD);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    logic [5:0] fns [2];
    ops[0] = 6'h3F; fns[0] = 6'h20;
    ops[1] = 6'h00; fns[1] = 6'h21;
    for (int k = 0; k < 2; k++) begin
      start(ops[k], fns[k]);
      mem_ready = 1'b1; #1;
      total++;
      if ({state, outs} !== {3'd0, PCW | IRW | MRD}) begin
        bad++; $display("FAIL illegal_fetch k=%0d state=%0d outs=%h", k, state, outs);
      end
      @(negedge clk); #1;
      total++;
      if ({state, outs} !== {3'd1, ILL}) begin
        bad++; $display("FAIL illegal_decode k=%0d state=%0d outs=%h expected state=1 outs=%h", k, state, outs, ILL);
      end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); mem_ready = 1'(i & 1); Zero = 1'(i & 2); #1;
        total++;
        if ({state, outs} !== {3'd5, 14'h0}) begin
          bad++; $display("FAIL illegal_halt k=%0d cyc=%0d state=%0d outs=%h expected state=5 outs=0000", k, i, state, outs);
        end
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
      total++;
      if ({state, outs} !== {3'd0, MRD}) begin
        bad++; $display("FAIL illegal_recover k=%0d state=%0d outs=%h expected state=0 outs=%h", k, state, outs, MRD);
      end
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      start(6'h00, 6'h20);
      for (int i = 1; i <= 14; i++) begin
        mem_ready = 1'b0; #1;
        total++;
        if ({state, outs} !== {3'd0, MRD}) begin
          bad++; $display("FAIL tmo_wait k=%0d cyc=%0d state=%0d outs=%h expected state=0 outs=%h", k, i, state, outs, MRD);
        end
        @(negedge clk);
      end
      mem_ready = 1'(k); #1;
      total++;
      if ({state, outs} !== {3'd0, (k != 0) ? (PCW | IRW | MRD) : TMO}) begin
        bad++; $display("FAIL tmo_edge k=%0d state=%0d outs=%h", k, state, outs);
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      total++;
      if ({state, outs} !== {(k != 0) ? 3'd1 : 3'd5, 14'h0}) begin
        bad++; $display("FAIL tmo_next k=%0d state=%0d outs=%h expected state=%0d outs=0000", k, state, outs, (k != 0) ? 1 : 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_addi_sw();
    test_sw_reset();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
